rgb2grey_pipe: RTL and testbench

Streaming pixel converter that turns an RGB pixel stream into greyscale and replicates the grey value onto all three output channels. It sits between the pixel source and the TMDS encoder path. It is the parametrised successor to the fixed 8-bit colour-to-grey path and adds:
- a generic component width
- run-time coefficient modes, switched only at frame boundaries
- valid/ready backpressure
- sideband pass-through

---
 rtl/rgb2grey_pkg.sv | 49 ++++
 rtl/rgb2grey_luma_mac.sv | 51 +++++
 rtl/rgb2grey_pipe.sv | 117 +++++++++++
 tb/tb_rgb2grey_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2grey_pkg.sv
// Shared types and constants for the RGB-to-greyscale pipeline.
package rgb2grey_pkg;

    localparam int MAX_DW    = 12;
    localparam int MAX_PIX_W = 3 * MAX_DW;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_601  = 2'd1,
        MODE_709  = 2'd2,
        MODE_AVG  = 2'd3
    } mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } coef_t;

    // Indexed by mode_t. Every grey set sums to 256 so Y stays in range;
    // the passthrough entry is never used for data.
    localparam coef_t [3:0] COEF_TABLE = {
        coef_t'{r: 8'd85, g: 8'd85,  b: 8'd86},   // MODE_AVG
        coef_t'{r: 8'd54, g: 8'd183, b: 8'd19},   // MODE_709
        coef_t'{r: 8'd77, g: 8'd150, b: 8'd29},   // MODE_601
        coef_t'{r: 8'd0,  g: 8'd0,   b: 8'd0}     // MODE_PASS
    };

    // Component idx of a {R,G,B} pixel of width dw: 0 = B, 1 = G, 2 = R.
    function automatic logic [MAX_DW-1:0] pix_comp(input logic [MAX_PIX_W-1:0] pix,
                                                   input int dw, input int idx);
        logic [MAX_PIX_W-1:0] sh;
        sh = pix >> (idx * dw);
        return sh[MAX_DW-1:0] & ((MAX_DW'(1) << dw) - MAX_DW'(1));
    endfunction

    function automatic logic [MAX_DW-1:0] pix_r(input logic [MAX_PIX_W-1:0] pix, input int dw);
        return pix_comp(pix, dw, 2);
    endfunction

    function automatic logic [MAX_DW-1:0] pix_g(input logic [MAX_PIX_W-1:0] pix, input int dw);
        return pix_comp(pix, dw, 1);
    endfunction

    function automatic logic [MAX_DW-1:0] pix_b(input logic [MAX_PIX_W-1:0] pix, input int dw);
        return pix_comp(pix, dw, 0);
    endfunction

endpackage

// File: rtl/rgb2grey_luma_mac.sv
// Weighted-sum datapath: registered products, then a rounded and clamped
// luma value computed from them. Handshake-free; the owner drives en_i.
module luma_mac
    import rgb2grey_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic [DW-1:0] r_i,
    input  logic [DW-1:0] g_i,
    input  logic [DW-1:0] b_i,
    input  coef_t         coef_i,
    output logic [DW-1:0] y_o
);

    logic [DW+7:0] prod_r_q, prod_g_q, prod_b_q;
    logic [DW+7:0] prod_r_d, prod_g_d, prod_b_d;
    logic [DW+9:0] sum, rnd;
    logic [DW+1:0] y_wide;

    // Multiply each component by its coefficient.
    always_comb begin
        prod_r_d = (DW+8)'(r_i) * (DW+8)'(coef_i.r);
        prod_g_d = (DW+8)'(g_i) * (DW+8)'(coef_i.g);
        prod_b_d = (DW+8)'(b_i) * (DW+8)'(coef_i.b);
    end

    // Product register (first pipeline stage), loaded on accepted beats only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
        end else if (en_i) begin
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
        end
    end

    // Sum, round to nearest, and clamp in case coefficients ever exceed 256.
    always_comb begin
        sum    = (DW+10)'(prod_r_q) + (DW+10)'(prod_g_q) + (DW+10)'(prod_b_q);
        rnd    = sum + (DW+10)'(128);
        y_wide = (DW+2)'(rnd >> 8);
        y_o    = (y_wide[DW+1:DW] != 2'b00) ? {DW{1'b1}} : y_wide[DW-1:0];
    end

endmodule

// File: rtl/rgb2grey_pipe.sv
// Two-stage RGB to greyscale converter with valid/ready backpressure,
// frame-aligned mode switching and sideband pass-through.
module rgb2grey_pipe
    import rgb2grey_pkg::*;
#(
    parameter int DW     = 8,
    parameter int USER_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [1:0]        mode_i,
    input  logic [3*DW-1:0]   s_data_i,
    input  logic [USER_W-1:0] s_user_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [3*DW-1:0]   m_data_o,
    output logic [USER_W-1:0] m_user_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [1:0]        mode_o
);

    localparam int PW = 3 * DW;

    logic [2:1]        vld_q, vld_d;
    mode_t             mode_q, mode_d;
    mode_t             beat_mode;
    mode_t             mode1_q;
    logic [PW-1:0]     pix1_q;
    logic [USER_W-1:0] user1_q, user2_q;
    logic [PW-1:0]     data2_q, data2_d;
    logic              s1_adv, s2_adv, acc, sof;
    logic [DW-1:0]     in_r, in_g, in_b, y;

    assign s2_adv    = !vld_q[2] || m_ready_i;
    assign s1_adv    = !vld_q[1] || s2_adv;
    assign s_ready_o = s1_adv;
    assign acc       = s_valid_i && s1_adv;
    assign sof       = s_user_i[0];

    assign in_r = DW'(pix_r(MAX_PIX_W'(s_data_i), DW));
    assign in_g = DW'(pix_g(MAX_PIX_W'(s_data_i), DW));
    assign in_b = DW'(pix_b(MAX_PIX_W'(s_data_i), DW));

    // A sof beat picks up the requested mode itself; others use the held mode.
    always_comb begin
        beat_mode = mode_q;
        mode_d    = mode_q;
        if (sof) beat_mode = mode_t'(mode_i);
        if (acc && sof) mode_d = mode_t'(mode_i);
    end

    // Stage valid flags follow the per-stage advance conditions.
    always_comb begin
        vld_d = vld_q;
        if (s1_adv) vld_d[1] = s_valid_i;
        if (s2_adv) vld_d[2] = vld_q[1];
    end

    luma_mac #(.DW(DW)) u_mac (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (acc),
        .r_i     (in_r),
        .g_i     (in_g),
        .b_i     (in_b),
        .coef_i  (COEF_TABLE[beat_mode]),
        .y_o     (y)
    );

    // Passthrough forwards the raw pixel; grey modes replicate Y.
    always_comb begin
        data2_d = {3{y}};
        if (mode1_q == MODE_PASS) data2_d = pix1_q;
    end

    // Valid flags and the active mode register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= '0;
            mode_q <= MODE_601;
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    // Stage 1 side registers: raw pixel, sideband and the beat's own mode.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix1_q  <= '0;
            user1_q <= '0;
            mode1_q <= MODE_601;
        end else if (acc) begin
            pix1_q  <= s_data_i;
            user1_q <= s_user_i;
            mode1_q <= beat_mode;
        end
    end

    // Stage 2 output register; holds while stalled downstream.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data2_q <= '0;
            user2_q <= '0;
        end else if (s2_adv && vld_q[1]) begin
            data2_q <= data2_d;
            user2_q <= user1_q;
        end
    end

    assign m_data_o  = data2_q;
    assign m_user_o  = user2_q;
    assign m_valid_o = vld_q[2];
    assign mode_o    = mode_q;

endmodule

// File: tb/tb_rgb2grey_pipe.sv
// Directed-vector and randomized-handshake bench for rgb2grey_pipe.
module tb_rgb2grey_pipe;

    logic        clk, rst_n;
    logic [1:0]  mode;
    logic [23:0] s_data;
    logic [1:0]  s_user;
    logic        s_valid, s_ready;
    logic [23:0] m_data;
    logic [1:0]  m_user;
    logic        m_valid, m_ready;
    logic [1:0]  mode_o;

    logic [1:0]  mode_w;
    logic [29:0] s_data_w;
    logic [1:0]  s_user_w;
    logic        s_valid_w, s_ready_w;
    logic [29:0] m_data_w;
    logic [1:0]  m_user_w;
    logic        m_valid_w, m_ready_w;
    logic [1:0]  mode_o_w;

    int n_tests = 0;
    int n_fail  = 0;

    rgb2grey_pipe #(.DW(8), .USER_W(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode),
        .s_data_i(s_data), .s_user_i(s_user), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_user_o(m_user), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .mode_o(mode_o)
    );

    rgb2grey_pipe #(.DW(10), .USER_W(2)) dut_w (
        .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode_w),
        .s_data_i(s_data_w), .s_user_i(s_user_w), .s_valid_i(s_valid_w), .s_ready_o(s_ready_w),
        .m_data_o(m_data_w), .m_user_o(m_user_w), .m_valid_o(m_valid_w), .m_ready_i(m_ready_w),
        .mode_o(mode_o_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  user;
        logic [23:0] pix;
        logic [23:0] exp;
        logic [1:0]  emode;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] g3(input logic [7:0] y);
        return {y, y, y};
    endfunction

    // Reference luma with independently written coefficients.
    function automatic logic [23:0] model(input logic [1:0] md, input logic [23:0] px);
        int r, g, b, y;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        y = 0;
        case (md)
            2'd1: y = (r * 77 + g * 150 + b * 29 + 128) / 256;
            2'd2: y = (r * 54 + g * 183 + b * 19 + 128) / 256;
            2'd3: y = (r * 85 + g * 85 + b * 86 + 128) / 256;
            default: return px;
        endcase
        if (y > 255) y = 255;
        return g3(8'(y));
    endfunction

    // Offer one beat to an empty pipe with m_ready high; report the output.
    task automatic beat8(input logic [1:0] md, input logic [1:0] usr, input logic [23:0] px,
                         output logic [23:0] od, output logic [1:0] ou, output logic [1:0] om,
                         output int lat);
        mode = md; s_user = usr; s_data = px; s_valid = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        s_valid = 1'b0;
        while (!m_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        od = m_data; ou = m_user; om = mode_o;
    endtask

    task automatic beat10(input logic [1:0] md, input logic [1:0] usr, input logic [29:0] px,
                          output logic [29:0] od, output int lat);
        mode_w = md; s_user_w = usr; s_data_w = px; s_valid_w = 1'b1; m_ready_w = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        s_valid_w = 1'b0;
        while (!m_valid_w && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        od = m_data_w;
    endtask

    initial begin
        logic [23:0] od, held_d;
        logic [1:0]  ou, om, held_u, mdl_mode;
        logic [29:0] od_w;
        int          lat;
        logic        bad;

        vecs[0]  = '{2'd1, 2'b01, {8'd255, 8'd0,   8'd0},   g3(8'd77),  2'd1};
        vecs[1]  = '{2'd2, 2'b01, {8'd0,   8'd255, 8'd0},   g3(8'd182), 2'd2};
        vecs[2]  = '{2'd3, 2'b00, {8'd255, 8'd255, 8'd255}, g3(8'd255), 2'd2};
        vecs[3]  = '{2'd3, 2'b01, {8'd30,  8'd60,  8'd90},  g3(8'd60),  2'd3};
        vecs[4]  = '{2'd3, 2'b10, {8'd1,   8'd2,   8'd3},   g3(8'd2),   2'd3};
        vecs[5]  = '{2'd0, 2'b01, {8'd12,  8'd34,  8'd56},  {8'd12, 8'd34, 8'd56}, 2'd0};
        vecs[6]  = '{2'd1, 2'b10, {8'd100, 8'd100, 8'd100}, g3(8'd100), 2'd0};
        vecs[7]  = '{2'd1, 2'b01, {8'd0,   8'd0,   8'd0},   g3(8'd0),   2'd1};
        vecs[8]  = '{2'd1, 2'b00, {8'd10,  8'd20,  8'd30},  g3(8'd18),  2'd1};
        vecs[9]  = '{2'd2, 2'b11, {8'd200, 8'd100, 8'd50},  g3(8'd117), 2'd2};
        vecs[10] = '{2'd3, 2'b01, {8'd0,   8'd0,   8'd255}, g3(8'd86),  2'd3};

        rst_n = 1'b0; mode = 2'd2; s_data = '0; s_user = '0; s_valid = 1'b0; m_ready = 1'b0;
        mode_w = 2'd0; s_data_w = '0; s_user_w = '0; s_valid_w = 1'b0; m_ready_w = 1'b0;

        // Reset state
        #12;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        check("rst_m_user",  32'(m_user),  32'd0);
        check("rst_mode_o",  32'(mode_o),  32'd1);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_mode_o_w", 32'(mode_o_w), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_mode_o", 32'(mode_o), 32'd1);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            beat8(vecs[i].mode, vecs[i].user, vecs[i].pix, od, ou, om, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_data", i), 32'(od), 32'(vecs[i].exp));
            check($sformatf("vec%0d_user", i), 32'(ou), 32'(vecs[i].user));
            check($sformatf("vec%0d_mode", i), 32'(om), 32'(vecs[i].emode));
        end

        // Sof beat arriving behind an older beat does not re-mode it
        beat8(2'd2, 2'b01, 24'h000000, od, ou, om, lat);
        @(posedge clk); #1;
        m_ready = 1'b0;
        mode = 2'd3; s_user = 2'b00; s_data = {8'd0, 8'd255, 8'd0}; s_valid = 1'b1;
        @(posedge clk); #1;
        s_user = 2'b01; s_data = {8'd0, 8'd255, 8'd0};
        check("mode_before_sof_accept", 32'(mode_o), 32'd2);
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("mode_after_sof_accept", 32'(mode_o), 32'd3);
        check("full_stall_s_ready", 32'(s_ready), 32'd0);
        held_d = m_data;
        @(posedge clk); #1;
        check("stall_hold_data", 32'(m_data), 32'(held_d));
        check("stall_hold_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        #1;
        check("older_beat_mode", 32'(m_data), 32'(g3(8'd182)));
        @(posedge clk); #1;
        check("sof_beat_mode", 32'(m_data), 32'(g3(8'd85)));
        check("sof_beat_user", 32'(m_user), 32'd1);
        @(posedge clk); #1;
        check("drained_valid", 32'(m_valid), 32'd0);

        // Reset with two beats in flight
        beat8(2'd2, 2'b01, {8'd0, 8'd255, 8'd0}, od, ou, om, lat);
        @(posedge clk); #1;
        m_ready = 1'b0;
        s_valid = 1'b1; s_user = 2'b00; s_data = 24'h102030;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        check("pre_rst_mode", 32'(mode_o), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_mode", 32'(mode_o), 32'd1);
        check("mid_rst_data", 32'(m_data), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        m_ready = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (m_valid) bad = 1'b1;
        end
        check("no_stale_after_rst", 32'(bad), 32'd0);
        beat8(2'd2, 2'b00, {8'd255, 8'd0, 8'd0}, od, ou, om, lat);
        check("post_rst_default_mode", 32'(od), 32'(g3(8'd77)));
        check("post_rst_mode_o", 32'(om), 32'd1);
        @(posedge clk); #1;

        // Random valid/ready against a scoreboard
        begin
            logic [23:0] q_d[$];
            logic [1:0]  q_u[$];
            logic [23:0] px, exp_d;
            logic [1:0]  exp_u;
            logic        acc, outh, stall_prev;
            int          sent, got, occ, cyc;
            sent = 0; got = 0; occ = 0; cyc = 0; stall_prev = 1'b0;
            mdl_mode = 2'd1; held_d = '0; held_u = '0;
            while ((sent < 1000 || occ > 0) && cyc < 20000) begin
                if (stall_prev) begin
                    check("rand_stall_data", 32'({m_user, m_data}), 32'({held_u, held_d}));
                end
                px = {8'(sent), 8'(sent + 1), 8'(sent + 2)};
                s_data  = px;
                s_user  = {1'(sent % 50 == 49), 1'(sent % 50 == 0)};
                mode    = 2'((sent / 50) % 4);
                s_valid = (sent < 1000) && ($urandom_range(1, 0) == 1);
                m_ready = (sent >= 1000) || ($urandom_range(1, 0) == 1);
                #1;
                check("rand_s_ready", 32'(s_ready), 32'(!(occ == 2 && !m_ready)));
                acc  = s_valid && s_ready;
                outh = m_valid && m_ready;
                if (outh) begin
                    if (q_d.size() == 0) begin
                        check("rand_unexpected_beat", 32'(m_data), 32'hFFFFFFFF);
                    end else begin
                        exp_d = q_d.pop_front();
                        exp_u = q_u.pop_front();
                        check("rand_out", 32'({m_user, m_data}), 32'({exp_u, exp_d}));
                    end
                    got++;
                end
                if (acc) begin
                    if (s_user[0]) mdl_mode = mode;
                    q_d.push_back(model(mdl_mode, px));
                    q_u.push_back(s_user);
                    sent++;
                end
                occ = occ + int'(acc) - int'(outh);
                stall_prev = m_valid && !m_ready;
                held_d = m_data; held_u = m_user;
                @(posedge clk); #1;
                cyc++;
            end
            s_valid = 1'b0;
            check("rand_beats_out", 32'(got), 32'd1000);
            check("rand_queue_empty", 32'(q_d.size()), 32'd0);
        end

        // Wide component build
        beat10(2'd1, 2'b01, {10'd1023, 10'd1023, 10'd1023}, od_w, lat);
        check("dw10_white_lat", 32'(lat), 32'd2);
        check("dw10_white", 32'(od_w), 32'({10'd1023, 10'd1023, 10'd1023}));
        @(posedge clk); #1;
        beat10(2'd3, 2'b00, {10'd1023, 10'd0, 10'd0}, od_w, lat);
        check("dw10_red_601", 32'(od_w), 32'({10'd308, 10'd308, 10'd308}));
        check("dw10_mode_o", 32'(mode_o_w), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
